rf_wport_arbiter: RTL and testbench
===================================

# rf_wport_arbiter

- Shares the single register-file write port (wEna/wAddr/wDin) between two requesters:
  - the in-order writeback stage, which cannot stall;
  - the late load-return path from the LSU, which uses valid/ready.
- LSU returns are held in a small in-order queue. Stale queued results are killed on WAW conflict.
- A starvation counter forces a pipeline bubble so queued loads always drain.
- Sits between the WB stage/LSU and the register file; exports a pending-register mask to the hazard unit.

## Interface
Parameters:
- DEPTH, 2: LSU queue entries; power of two, ≥2.
- STARVE_MAX, 4: consecutive lost arbitration cycles before stall_req.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- wb_valid  in  1  writeback request; always accepted.
- wb_addr  in  5  writeback destination register.
- wb_data  in  32  writeback data.
- lsu_valid  in  1  load-return request.
- lsu_ready  out  1  queue can accept; = !full, combinational from state only.
- lsu_addr  in  5  load destination register.
- lsu_data  in  32  load data.
- rf_wEna  out  1  register-file write enable, registered.
- rf_wAddr  out  5  register-file write address, registered.
- rf_wDin  out  32  register-file write data, registered.
- pend_mask  out  32  bit r set when a live (unkilled) queued entry targets r; bit 0 always 0.
- stall_req  out  1  asks the pipeline to issue no writeback next cycle, registered.

## Operation
Definitions:
- LSU handshake = lsu_valid && lsu_ready in the same cycle.
- Each queue entry holds {live, addr, data}.

Priority each cycle (at most one grant):
1. wb_valid:
   - Output register loads {1, wb_addr, wb_data}.
   - Every queued entry with addr == wb_addr gets live=0 (WAW kill: the queued load is older).
2. Otherwise, if the queue is non-empty:
   - Pop the head.
   - If head is live, output loads {1, addr, data}; if killed, output loads wEna=0.
3. Otherwise, wEna=0. rf_wAddr/rf_wDin hold their previous values.

Register 0:
- Any grant targeting r0 drives wEna=0, but the request is consumed normally.
- An LSU push with addr 0 enters the queue with live=0.

Simultaneous push + wb_valid, same address:
- The incoming LSU entry is pushed with live=0 (it is older than the writeback).

Push and pop in the same cycle:
- Allowed. Count is unchanged.
- When the queue is full, lsu_ready=0 in that cycle regardless of the pop.

Starvation:
- Counter increments when the queue is non-empty and wb_valid wins.
- Counter clears on any pop or when the queue is empty; it saturates at STARVE_MAX.
- stall_req=1 in the cycle after the counter reaches STARVE_MAX, and stays 1 until a pop occurs.
- The pipeline guarantees wb_valid=0 in the cycle stall_req=1 is seen.

Width: the counter is clog2(STARVE_MAX+1) bits; queue pointers are clog2(DEPTH) bits plus a wrap bit.

## Timing
- Reset values: rf_wEna=0, rf_wAddr=0, rf_wDin=0, stall_req=0, pend_mask=0, queue empty, counter 0. lsu_ready=1 during and after reset.
- Latency:
  - A writeback accepted in cycle N gives rf_wEna=1 in cycle N+1; the register file updates at the end of N+1.
  - An LSU push into an empty queue with wb_valid=0 can pop in the push cycle N+1 (the entry is visible to the head next cycle), so rf_wEna=1 in cycle N+2.
- pend_mask:
  - Updates on the edge after a push, pop or kill.
  - A bit clears in the cycle its entry moves to the output register.
- Reset asserted mid-operation: queue, counter and outputs clear immediately (asynchronous); in-flight entries are discarded.
- The queue never drops a live entry; ordering is strictly FIFO among LSU entries.

## Structure
- Shared package rf_pkg:
  - REG_AW=5, DATA_W=32.
  - typedef rf_wreq_t {addr, data}.
  - queue entry type {live, rf_wreq_t}.
- One sub-module, rf_wq_fifo:
  - DEPTH-entry circular buffer with per-entry live bit.
  - Kill port: a 5-bit address plus enable clears matching live bits.
  - Exports a combinational 32-bit mask of live entry addresses.
- The top holds the arbitration mux, output register and starvation counter.

## Test plan
1. Reset, then LSU push {r5, 0xA5A5_0001} with wb idle → rf_wEna=1, wAddr=5, wDin=0xA5A5_0001 two cycles later; pend_mask[5] is 1 for exactly one cycle.
2. Same-cycle LSU push {r7, 0x11} and wb {r7, 0x22} → only r7=0x22 is written; the killed entry is popped later with wEna=0; pend_mask[7] never rises.
3. Fill the queue (DEPTH pushes) with wb_valid held high → lsu_ready=0 when full; stall_req rises exactly after STARVE_MAX lost cycles; drop wb_valid → head pops, stall_req falls.
4. Writeback to r0 with data 0xFFFF_FFFF → rf_wEna stays 0; an LSU push to r0 is consumed with no write.
5. Pulse rst_n low while the queue is full and stall_req=1 → all outputs reach their reset values immediately and lsu_ready=1.
6. Random mix of 1000 writeback and LSU requests, checked against a reference scoreboard for final register values and per-address write order.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared register-file write-port types: request payload and queued load entry.
package rf_pkg;

    localparam int REG_AW   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 1 << REG_AW;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [DATA_W-1:0] data;
    } rf_wreq_t;

    typedef struct packed {
        logic     live;
        rf_wreq_t req;
    } rf_qentry_t;

    function automatic logic [NUM_REGS-1:0] addr_onehot(input logic [REG_AW-1:0] addr);
        logic [NUM_REGS-1:0] mask;
        mask       = '0;
        mask[addr] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/rf_wq_fifo.sv
// In-order queue of late load returns; each entry carries a live bit that a
// younger writeback to the same register can clear (WAW kill).
module rf_wq_fifo
    import rf_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_push,
    input  rf_qentry_t          i_push_entry,
    input  logic                i_pop,
    input  logic                i_kill_en,
    input  logic [REG_AW-1:0]   i_kill_addr,
    output rf_qentry_t          o_head,
    output logic                o_empty,
    output logic                o_full,
    output logic [NUM_REGS-1:0] o_live_mask
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0]     r_wr_ptr;
    logic [PW:0]     r_rd_ptr;
    rf_qentry_t      w_entry [DEPTH];
    logic [NUM_REGS-1:0] w_mask;

    // Popped slots drop their live bit so the mask only needs to scan live bits,
    // not occupancy.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            rf_qentry_t r_entry;
            logic       w_wr_hit;
            logic       w_rd_hit;

            assign w_wr_hit = i_push && (r_wr_ptr[PW-1:0] == PW'(gi));
            assign w_rd_hit = i_pop  && (r_rd_ptr[PW-1:0] == PW'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_entry <= '0;
                end else if (w_wr_hit) begin
                    r_entry <= i_push_entry;
                end else if (w_rd_hit) begin
                    r_entry.live <= 1'b0;
                end else if (i_kill_en && (r_entry.req.addr == i_kill_addr)) begin
                    r_entry.live <= 1'b0;
                end
            end

            assign w_entry[gi] = r_entry;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_entry[i].live) w_mask = w_mask | addr_onehot(w_entry[i].req.addr);
        end
    end

    assign o_live_mask = {w_mask[NUM_REGS-1:1], 1'b0};
    assign o_head      = w_entry[r_rd_ptr[PW-1:0]];
    assign o_empty     = (r_wr_ptr == r_rd_ptr);
    assign o_full      = (r_wr_ptr[PW] != r_rd_ptr[PW]) && (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);

endmodule

// File: rtl/rf_wport_arbiter.sv
// Shares the register-file write port between the non-stallable writeback stage
// and queued LSU load returns; a starvation counter requests a bubble to drain loads.
module rf_wport_arbiter
    import rf_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wb_valid,
    input  logic [REG_AW-1:0]   wb_addr,
    input  logic [DATA_W-1:0]   wb_data,
    input  logic                lsu_valid,
    output logic                lsu_ready,
    input  logic [REG_AW-1:0]   lsu_addr,
    input  logic [DATA_W-1:0]   lsu_data,
    output logic                rf_wEna,
    output logic [REG_AW-1:0]   rf_wAddr,
    output logic [DATA_W-1:0]   rf_wDin,
    output logic [NUM_REGS-1:0] pend_mask,
    output logic                stall_req
);

    localparam int CW = $clog2(STARVE_MAX + 1);

    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    rf_qentry_t          w_head;
    rf_qentry_t          w_push_entry;
    logic [NUM_REGS-1:0] w_live_mask;

    logic                r_wena;
    logic [REG_AW-1:0]   r_waddr;
    logic [DATA_W-1:0]   r_wdin;
    logic [CW-1:0]       r_starve;
    logic                r_stall;

    logic                w_wena_next;
    logic [REG_AW-1:0]   w_waddr_next;
    logic [DATA_W-1:0]   w_wdin_next;
    logic [CW-1:0]       w_starve_next;
    logic                w_stall_next;

    assign lsu_ready = !w_full;
    assign w_push    = lsu_valid && !w_full;
    assign w_pop     = !wb_valid && !w_empty;

    // A load colliding with a same-cycle writeback is older, so it enters already dead.
    always_comb begin
        w_push_entry          = '0;
        w_push_entry.req.addr = lsu_addr;
        w_push_entry.req.data = lsu_data;
        w_push_entry.live     = (lsu_addr != '0) && !(wb_valid && (wb_addr == lsu_addr));
    end

    rf_wq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .i_kill_en    (wb_valid),
        .i_kill_addr  (wb_addr),
        .o_head       (w_head),
        .o_empty      (w_empty),
        .o_full       (w_full),
        .o_live_mask  (w_live_mask)
    );

    always_comb begin
        w_wena_next  = 1'b0;
        w_waddr_next = r_waddr;
        w_wdin_next  = r_wdin;
        if (wb_valid) begin
            w_wena_next  = (wb_addr != '0);
            w_waddr_next = wb_addr;
            w_wdin_next  = wb_data;
        end else if (w_pop) begin
            w_wena_next  = w_head.live && (w_head.req.addr != '0);
            w_waddr_next = w_head.req.addr;
            w_wdin_next  = w_head.req.data;
        end
    end

    // Queue non-empty without a pop implies the writeback won this cycle.
    always_comb begin
        w_starve_next = r_starve;
        if (w_pop || w_empty) begin
            w_starve_next = '0;
        end else if (r_starve != CW'(STARVE_MAX)) begin
            w_starve_next = r_starve + CW'(1);
        end
        w_stall_next = w_pop ? 1'b0 : (r_stall || (w_starve_next == CW'(STARVE_MAX)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wena   <= 1'b0;
            r_waddr  <= '0;
            r_wdin   <= '0;
            r_starve <= '0;
            r_stall  <= 1'b0;
        end else begin
            r_wena   <= w_wena_next;
            r_waddr  <= w_waddr_next;
            r_wdin   <= w_wdin_next;
            r_starve <= w_starve_next;
            r_stall  <= w_stall_next;
        end
    end

    assign rf_wEna   = r_wena;
    assign rf_wAddr  = r_waddr;
    assign rf_wDin   = r_wdin;
    assign stall_req = r_stall;
    assign pend_mask = w_live_mask;

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed checks of the write-port arbiter followed by a randomized mix
// scored against program-order register values and per-register write order.
module tb_rf_wport_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_addr;
    logic [31:0] lsu_data;
    logic        rf_wEna;
    logic [4:0]  rf_wAddr;
    logic [31:0] rf_wDin;
    logic [31:0] pend_mask;
    logic        stall_req;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] ref_rf   [32];
    logic [31:0] dut_rf   [32];
    logic [31:0] last_seq [32];
    logic [31:0] seq;
    int          issued;

    always #5 clk = ~clk;

    rf_wport_arbiter #(
        .DEPTH      (2),
        .STARVE_MAX (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_addr  (lsu_addr),
        .lsu_data  (lsu_data),
        .rf_wEna   (rf_wEna),
        .rf_wAddr  (rf_wAddr),
        .rf_wDin   (rf_wDin),
        .pend_mask (pend_mask),
        .stall_req (stall_req)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_vec++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_valid  = 1'b0;
        wb_addr   = '0;
        wb_data   = '0;
        lsu_valid = 1'b0;
        lsu_addr  = '0;
        lsu_data  = '0;
    endtask

    // Fills both queue slots under continuous writebacks and stops in the stall cycle.
    task automatic fill_to_stall();
        wb_valid = 1'b1; wb_addr = 5'd1; wb_data = 32'h0000_1111;
        lsu_valid = 1'b1; lsu_addr = 5'd10; lsu_data = 32'h0000_0100;
        check("fill_ready_a", 32'(lsu_ready), 32'd1);
        tick();
        check("fill_ready_b", 32'(lsu_ready), 32'd1);
        check("fill_pend_b", pend_mask, 32'h0000_0400);
        lsu_addr = 5'd11; lsu_data = 32'h0000_0101;
        tick();
        check("fill_ready_full", 32'(lsu_ready), 32'd0);
        check("fill_pend_full", pend_mask, 32'h0000_0C00);
        check("stall_c", 32'(stall_req), 32'd0);
        lsu_valid = 1'b0;
        tick();
        check("stall_d", 32'(stall_req), 32'd0);
        tick();
        check("stall_e", 32'(stall_req), 32'd0);
        tick();
        check("stall_rise", 32'(stall_req), 32'd1);
        check("stall_full", 32'(lsu_ready), 32'd0);
        check("stall_wb_addr", 32'(rf_wAddr), 32'd1);
    endtask

    task automatic observe();
        if (rf_wEna) begin
            check("rand_nonzero_addr", 32'(rf_wAddr != 5'd0), 32'd1);
            check("rand_write_order", 32'(rf_wDin > last_seq[rf_wAddr]), 32'd1);
            last_seq[rf_wAddr] = rf_wDin;
            dut_rf[rf_wAddr]   = rf_wDin;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        check("rst_wena", 32'(rf_wEna), 32'd0);
        check("rst_waddr", 32'(rf_wAddr), 32'd0);
        check("rst_wdin", rf_wDin, 32'd0);
        check("rst_stall", 32'(stall_req), 32'd0);
        check("rst_pend", pend_mask, 32'd0);
        check("rst_ready", 32'(lsu_ready), 32'd1);
        rst_n = 1'b1;
        tick();

        // Load return into an empty queue, no writeback competing.
        lsu_valid = 1'b1; lsu_addr = 5'd5; lsu_data = 32'hA5A5_0001;
        tick();
        idle();
        check("t1_pend_n1", pend_mask, 32'h0000_0020);
        check("t1_wena_n1", 32'(rf_wEna), 32'd0);
        tick();
        check("t1_wena_n2", 32'(rf_wEna), 32'd1);
        check("t1_waddr_n2", 32'(rf_wAddr), 32'd5);
        check("t1_wdin_n2", rf_wDin, 32'hA5A5_0001);
        check("t1_pend_n2", pend_mask, 32'd0);
        tick();
        check("t1_wena_n3", 32'(rf_wEna), 32'd0);

        // Same-cycle load and writeback to r7: load is killed on entry.
        lsu_valid = 1'b1; lsu_addr = 5'd7; lsu_data = 32'h0000_0011;
        wb_valid  = 1'b1; wb_addr  = 5'd7; wb_data  = 32'h0000_0022;
        tick();
        idle();
        check("t2_wena", 32'(rf_wEna), 32'd1);
        check("t2_waddr", 32'(rf_wAddr), 32'd7);
        check("t2_wdin", rf_wDin, 32'h0000_0022);
        check("t2_pend", pend_mask, 32'd0);
        tick();
        check("t2_killed_pop_wena", 32'(rf_wEna), 32'd0);
        check("t2_pend_after", pend_mask, 32'd0);
        tick();
        check("t2_idle_wena", 32'(rf_wEna), 32'd0);

        // Starvation and drain.
        fill_to_stall();
        wb_valid = 1'b0;
        tick();
        check("t3_pop1_wena", 32'(rf_wEna), 32'd1);
        check("t3_pop1_waddr", 32'(rf_wAddr), 32'd10);
        check("t3_pop1_wdin", rf_wDin, 32'h0000_0100);
        check("t3_stall_fall", 32'(stall_req), 32'd0);
        check("t3_pend_after_pop1", pend_mask, 32'h0000_0800);
        check("t3_ready_after_pop1", 32'(lsu_ready), 32'd1);
        tick();
        check("t3_pop2_waddr", 32'(rf_wAddr), 32'd11);
        check("t3_pop2_wdin", rf_wDin, 32'h0000_0101);
        check("t3_pend_empty", pend_mask, 32'd0);
        tick();
        check("t3_idle_wena", 32'(rf_wEna), 32'd0);

        // Register 0 writes are consumed silently.
        wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
        tick();
        idle();
        check("t4_wb_r0_wena", 32'(rf_wEna), 32'd0);
        lsu_valid = 1'b1; lsu_addr = 5'd0; lsu_data = 32'h0000_0033;
        tick();
        idle();
        check("t4_lsu_r0_pend", pend_mask, 32'd0);
        check("t4_lsu_r0_wena_push", 32'(rf_wEna), 32'd0);
        tick();
        check("t4_lsu_r0_wena_pop", 32'(rf_wEna), 32'd0);
        check("t4_lsu_r0_ready", 32'(lsu_ready), 32'd1);

        // Asynchronous reset while full and stalled.
        fill_to_stall();
        idle();
        rst_n = 1'b0;
        #1;
        check("t5_wena", 32'(rf_wEna), 32'd0);
        check("t5_waddr", 32'(rf_wAddr), 32'd0);
        check("t5_wdin", rf_wDin, 32'd0);
        check("t5_stall", 32'(stall_req), 32'd0);
        check("t5_pend", pend_mask, 32'd0);
        check("t5_ready", 32'(lsu_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        tick();
        check("t5_discard_wena", 32'(rf_wEna), 32'd0);
        tick();
        check("t5_discard_wena2", 32'(rf_wEna), 32'd0);

        // Random mix; data carries a global sequence number in program order.
        for (int r = 0; r < 32; r++) begin
            ref_rf[r] = '0; dut_rf[r] = '0; last_seq[r] = '0;
        end
        seq    = '0;
        issued = 0;
        while (issued < 1000) begin
            idle();
            if ($urandom_range(0, 9) < 6) begin
                lsu_valid = 1'b1;
                lsu_addr  = 5'($urandom_range(0, 7));
                lsu_data  = 32'hFFFF_0000;
                if (lsu_ready) begin
                    seq      = seq + 1;
                    lsu_data = seq;
                    if (lsu_addr != 5'd0) ref_rf[lsu_addr] = seq;
                    issued++;
                end
            end
            if (!stall_req && ($urandom_range(0, 9) < 5)) begin
                wb_valid = 1'b1;
                wb_addr  = 5'($urandom_range(0, 7));
                seq      = seq + 1;
                wb_data  = seq;
                if (wb_addr != 5'd0) ref_rf[wb_addr] = seq;
                issued++;
            end
            tick();
            observe();
        end
        idle();
        for (int c = 0; c < 20; c++) begin
            tick();
            observe();
        end
        check("rand_drained_pend", pend_mask, 32'd0);
        check("rand_drained_ready", 32'(lsu_ready), 32'd1);
        for (int r = 1; r < 32; r++) begin
            check($sformatf("rand_final_r%0d", r), dut_rf[r], ref_rf[r]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
